// File: rtl/dff_pipe.sv
// Elastic register pipeline: per-stage valid flags, bubble collapse under stall, synchronous flush.
// Define DFF_PIPE_QBAR_EN to add the complemented output port qbar.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             d,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         clr,
    output logic [WIDTH-1:0]             q,
`ifdef DFF_PIPE_QBAR_EN
    output logic [WIDTH-1:0]             qbar,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data      [DEPTH];
    logic [WIDTH-1:0] data_next [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_next;
    logic [DEPTH-1:0] can_accept;
    logic [OCC_W-1:0] occ_next;

    assign out_valid = vld[DEPTH-1] && !clr;
    assign in_ready  = can_accept[0] && !clr;
    assign q         = data[DEPTH-1];
`ifdef DFF_PIPE_QBAR_EN
    assign qbar      = ~data[DEPTH-1];
`endif

    // A stage can take a word if it is empty or its own word moves on this cycle;
    // evaluated from the output end backwards so stalls ripple towards the input.
    always_comb begin
        logic acc;
        acc = !vld[DEPTH-1] || (out_valid && out_ready);
        can_accept = '0;
        can_accept[DEPTH-1] = acc;
        for (int k = DEPTH-2; k >= 0; k--) begin
            acc = !vld[k] || acc;
            can_accept[k] = acc;
        end
    end

    always_comb begin
        vld_next  = vld;
        data_next = data;
        occ_next  = '0;
        if (clr) begin
            vld_next = '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_next[k] = RESET_VAL;
            end
        end else begin
            if (can_accept[0]) begin
                vld_next[0] = in_valid;
                if (in_valid) begin
                    data_next[0] = d;
                end
            end
            // Data only moves with a valid word, so an emptied stage keeps its last value.
            for (int k = 1; k < DEPTH; k++) begin
                if (can_accept[k]) begin
                    vld_next[k] = vld[k-1];
                    if (vld[k-1]) begin
                        data_next[k] = data[k-1];
                    end
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_next = occ_next + OCC_W'(vld_next[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld       <= '0;
            occupancy <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= RESET_VAL;
            end
        end else begin
            vld       <= vld_next;
            data      <= data_next;
            occupancy <= occ_next;
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4): vector tables, scoreboard, and corner-case sequences.
// Checks qbar when DFF_PIPE_QBAR_EN is defined.
module tb_dff_pipe;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] d = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       clr = 1'b0;
   logic [7:0] q;
`ifdef DFF_PIPE_QBAR_EN
   logic [7:0] qbar;
`endif
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] occupancy;

   dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
      .clk(clk),
      .reset(reset),
      .d(d),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .clr(clr),
      .q(q),
`ifdef DFF_PIPE_QBAR_EN
      .qbar(qbar),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         acceptCycle;
   } sb_t;

   typedef struct {
      logic       iv;
      logic [7:0] dv;
      logic       ordy;
      logic       cl;
      logic       expInReady;
      logic       expOutValid;
      logic [2:0] expOcc;
   } vec_t;

   sb_t  sbQ[$];
   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;
   int   cycleNum = 0;
   bit   checkLat = 1'b0;

   logic       sampInReady;
   logic       sampOutValid;
   logic [7:0] sampQ;
   logic [2:0] sampOcc;

   function automatic vec_t mkVec(logic iv, logic [7:0] dv, logic ordy, logic cl,
                                  logic er, logic ev, logic [2:0] eo);
      vec_t v;
      v.iv = iv; v.dv = dv; v.ordy = ordy; v.cl = cl;
      v.expInReady = er; v.expOutValid = ev; v.expOcc = eo;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample just after, score transfers, then take the rising edge.
   task automatic applyStimulus(input logic iv, input logic [7:0] dv, input logic ordy, input logic cl);
      sb_t e;
      @(negedge clk);
      in_valid = iv; d = dv; out_ready = ordy; clr = cl;
      #1;
      sampInReady  = in_ready;
      sampOutValid = out_valid;
      sampQ        = q;
      sampOcc      = occupancy;
      if (out_valid && out_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("sb_unexpected_word", 32'(q), 32'hDEAD);
         end else begin
            e = sbQ.pop_front();
            checkOutput("sb_q", 32'(q), 32'(e.data));
`ifdef DFF_PIPE_QBAR_EN
            checkOutput("sb_qbar", 32'(qbar), 32'(~e.data));
`endif
            if (checkLat) checkOutput("sb_latency", 32'(cycleNum - e.acceptCycle), 32'd4);
         end
      end
      if (in_valid && in_ready) begin
         e.data = dv;
         e.acceptCycle = cycleNum;
         sbQ.push_back(e);
      end
      @(posedge clk);
      if (cl) sbQ.delete();
      cycleNum++;
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         n++;
      end
      checkOutput({tag, "_drain_left"}, 32'(sbQ.size()), 32'd0);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_q"}, 32'(q), 32'h00);
      checkOutput({tag, "_occupancy"}, 32'(occupancy), 32'd0);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef DFF_PIPE_QBAR_EN
      checkOutput({tag, "_qbar"}, 32'(qbar), 32'hFF);
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset held low for two cycles, then released
      repeat (2) @(posedge clk);
      #1;
      checkIdle("reset_held");
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkIdle("reset_released");

      // Continuous stream with the consumer always ready
      checkLat = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
         checkOutput($sformatf("stream_in_ready_%0d", i), 32'(sampInReady), 32'd1);
      end
      drain(20, "stream");
      checkLat = 1'b0;

      // Backpressure fill, then release; followed by bubble collapse behind a stalled head
      vecs.push_back(mkVec(1, 8'hA0, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'hA1, 0, 0, 1, 0, 1));
      vecs.push_back(mkVec(1, 8'hA2, 0, 0, 1, 0, 2));
      vecs.push_back(mkVec(1, 8'hA3, 0, 0, 1, 0, 3));
      vecs.push_back(mkVec(1, 8'hA4, 0, 0, 0, 1, 4));
      vecs.push_back(mkVec(1, 8'hA4, 0, 0, 0, 1, 4));
      vecs.push_back(mkVec(1, 8'hA4, 1, 0, 1, 1, 4));
      vecs.push_back(mkVec(1, 8'hA5, 1, 0, 1, 1, 4));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 1, 4));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 1, 3));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 1, 2));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 1, 1));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'h11, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 0, 1));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 0, 1));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 0, 1));
      vecs.push_back(mkVec(1, 8'h22, 0, 0, 1, 1, 1));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 1, 2));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 1, 2));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 1, 2));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 1, 2));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 1, 1));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 0, 0));
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].iv, vecs[i].dv, vecs[i].ordy, vecs[i].cl);
         checkOutput($sformatf("vec%0d_in_ready", i), 32'(sampInReady), 32'(vecs[i].expInReady));
         checkOutput($sformatf("vec%0d_out_valid", i), 32'(sampOutValid), 32'(vecs[i].expOutValid));
         checkOutput($sformatf("vec%0d_occupancy", i), 32'(sampOcc), 32'(vecs[i].expOcc));
      end
      checkOutput("vectors_words_left", 32'(sbQ.size()), 32'd0);

      // Flush with three words in flight and a competing input
      applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h34, 1'b1, 1'b1);
      checkOutput("clr_in_ready", 32'(sampInReady), 32'd0);
      checkOutput("clr_out_valid", 32'(sampOutValid), 32'd0);
      checkOutput("clr_occupancy_before", 32'(sampOcc), 32'd3);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("post_clr_out_valid", 32'(sampOutValid), 32'd0);
      checkOutput("post_clr_occupancy", 32'(sampOcc), 32'd0);
      checkOutput("post_clr_q", 32'(sampQ), 32'h00);

      // Asynchronous reset between edges while words are in flight
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      checkOutput("pre_async_occupancy", 32'(occupancy), 32'd3);
      reset = 1'b0;
      #1;
      checkIdle("async_reset");
      sbQ.delete();
      #10;
      reset = 1'b1;
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
      checkOutput("after_reset_in_ready", 32'(sampInReady), 32'd1);
      drain(20, "after_reset");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("final_out_valid", 32'(sampOutValid), 32'd0);
      checkOutput("final_occupancy", 32'(sampOcc), 32'd0);
      checkOutput("final_q", 32'(sampQ), 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
